ex_div: RTL and testbench
=========================

# ex_div

Iterative RV32M divide unit for the EX stage; executes DIV, DIVU, REM and REMU. The EX stage decodes a divide instruction from the decode-to-execute pipeline register and asserts `start_i`. The unit raises `busy_o` so the front of the pipeline and the decode-to-execute register hold, runs a 32-iteration restoring division, and returns a one-cycle writeback. Special cases (divide-by-zero, signed overflow) bypass iteration and follow the RISC-V spec results.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; iteration count equals `XLEN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  request to start a divide; sampled only in IDLE or DONE.
- `op_i`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend_i`  in  XLEN  rs1 value (op1).
- `divisor_i`  in  XLEN  rs2 value (op2).
- `rd_addr_i`  in  5  destination register.
- `flush_i`  in  1  abort the current operation (branch/jump taken).
- `busy_o`  out  1  stall request to the pipeline.
- `result_o`  out  XLEN  quotient or remainder.
- `result_valid_o`  out  1  one-cycle writeback strobe.
- `rd_addr_o`  out  5  destination register of the result.
- `reg_wen_o`  out  1  register write enable; equals `result_valid_o`.

## Operation
- States: IDLE, CALC, DONE.
- **Capture.** On accept, the unit registers `op_i`, `rd_addr_i`, and the operand signs. For signed ops it registers the absolute values of both operands; for unsigned ops it registers the raw values. Inputs are don't-care after capture.
- **IDLE → DONE** (special case, no iteration):
  - Divisor == 0: DIV/DIVU give quotient 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- **IDLE → CALC** (all other cases): iteration counter = 0, remainder = 0, quotient = dividend magnitude.
- **CALC, each cycle** (one restoring step):
  - Shift {remainder, quotient} left by 1.
  - Trial = remainder − divisor magnitude, computed XLEN+1 bits wide.
  - If the trial is non-negative: remainder = trial and quotient LSB = 1. Otherwise quotient LSB = 0.
  - Counter increments. After the XLEN-th step, go to DONE.
- **DONE, sign fix:**
  - Quotient is negated when the dividend sign differs from the divisor sign (DIV only).
  - Remainder takes the sign of the dividend (REM only).
  - Result is selected by `op_i[1]`.
- **DONE exits:**
  - If `start_i` is high, the unit accepts the next op (back-to-back).
  - Otherwise it returns to IDLE.
- **Flush.**
  - `flush_i` in any state: next state IDLE; no `result_valid_o` is produced.
  - `flush_i` takes priority over `start_i` in the same cycle.
- `busy_o` = (`start_i` && state ∈ {IDLE, DONE} && !`flush_i`) || state == CALC. It is combinational, so the pipeline stalls in the same cycle as the request.

## Timing
- **Reset:** state IDLE. `busy_o`, `result_o`, `result_valid_o`, `rd_addr_o` and `reg_wen_o` are all 0. Reset mid-operation discards the op.
- **Normal latency:**
  - Accept edge E0; CALC occupies edges E1..E32.
  - DONE is the cycle after E32: `result_valid_o` = 1 and `busy_o` = 0, so the pipeline advances at the next edge.
  - Total: 33 cycles from the accept edge to the valid cycle.
- **Special-case latency:** DONE is the cycle after accept, so `result_valid_o` appears 1 cycle after accept.
- `result_o` and `rd_addr_o` are registered and hold their last values outside DONE. `result_valid_o` and `reg_wen_o` are 0 outside DONE.
- `result_valid_o` is never high for two consecutive cycles for the same op.

## Test plan
- **DIVU 100 / 7:** `result_o` = 14 with `result_valid_o` 33 cycles after accept; `busy_o` high in cycles 0..32. REMU with the same operands gives 2.
- **Signed:** DIV −7 / 2 gives 0xFFFFFFFD; REM −7 / 2 gives 0xFFFFFFFF; DIV 7 / −2 gives 0xFFFFFFFD; REM 7 / −2 gives 1.
- **Divide by zero:** DIVU 5 / 0 gives 0xFFFFFFFF; REM 5 / 0 gives 5. Both are valid 1 cycle after accept with no CALC cycles.
- **Overflow:** DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0. Both complete in 1 cycle.
- **Flush and reset mid-op:**
  - `flush_i` at CALC iteration 10: the unit is in IDLE the next cycle, `busy_o` = 0, and no valid strobe follows.
  - Same scenario with `rst` instead of `flush_i`: all outputs are 0 the next cycle.
- **Back-to-back:** `start_i` held high in DONE with a new op (DIVU 9 / 3) and `rd_addr_i` = 5. The first result writes back, and the second yields 3 with `rd_addr_o` = 5 exactly 33 cycles later. Operand changes during CALC have no effect.

Source files
------------

// File: rtl/ex_div.sv
// ex_div: iterative 32-step restoring divider for DIV/DIVU/REM/REMU.
// Signed operands are reduced to magnitudes on capture, and signs are
// re-applied on the final step. Divide-by-zero and signed overflow are
// resolved at capture time without iterating.
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [1:0]          op_p0;
  logic [4:0]          rd_p0;
  logic                sign_a_p0;
  logic                sign_b_p0;
  logic [XLEN-1:0]     dvs_p0;
  logic [XLEN-1:0]     quo_p0;
  logic [XLEN-1:0]     rem_p0;
  logic [CNT_W-1:0]    cnt_p0;

  // Conditional two's-complement negation, used both for taking magnitudes
  // on capture and for re-applying signs to the final quotient/remainder.
  function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] v,
                                               input logic neg);
    logic signed [XLEN-1:0] s;
    s = signed'(v);
    return neg ? unsigned'(-s) : v;
  endfunction

  logic            is_signed;
  logic            sign_a_in;
  logic            sign_b_in;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            accept;

  assign is_signed = ~op_i[0];
  assign sign_a_in = is_signed & dividend_i[XLEN-1];
  assign sign_b_in = is_signed & divisor_i[XLEN-1];
  assign div_zero  = (divisor_i == '0);
  assign ovf       = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (divisor_i == '1);
  assign special   = div_zero || ovf;
  assign special_res = div_zero ? (op_i[1] ? dividend_i : '1)
                                : (op_i[1] ? '0 : dividend_i);
  assign accept    = start_i && (state == IDLE || state == DONE) && !flush_i;
  assign busy_o    = accept || (state == CALC);
  assign reg_wen_o = result_valid_o;

  // One restoring step: the shifted partial remainder is XLEN+1 bits so a
  // divisor with its MSB set still compares correctly.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fin_res;
  logic            last;

  assign shifted = {rem_p0, quo_p0[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_p0};
  assign rem_nxt = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_nxt = {quo_p0[XLEN-2:0], ~trial[XLEN]};
  assign q_fix   = sign_fix(quo_nxt, (op_p0 == 2'b00) && (sign_a_p0 ^ sign_b_p0));
  assign r_fix   = sign_fix(rem_nxt, (op_p0 == 2'b10) && sign_a_p0);
  assign fin_res = op_p0[1] ? r_fix : q_fix;
  assign last    = (cnt_p0 == CNT_W'(XLEN - 1));

  // Operand capture and iteration datapath (no reset: contents only matter after accept).
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0     <= op_i;
      rd_p0     <= rd_addr_i;
      sign_a_p0 <= sign_a_in;
      sign_b_p0 <= sign_b_in;
      dvs_p0    <= sign_fix(divisor_i, sign_b_in);
      quo_p0    <= sign_fix(dividend_i, sign_a_in);
      rem_p0    <= '0;
      cnt_p0    <= '0;
    end else if (state == CALC) begin
      rem_p0    <= rem_nxt;
      quo_p0    <= quo_nxt;
      cnt_p0    <= cnt_p0 + 1'b1;
    end
  end

  // Control FSM with registered writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      rd_addr_o      <= '0;
    end else begin
      result_valid_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_i) begin
              if (special) begin
                state          <= DONE;
                result_valid_o <= 1'b1;
                result_o       <= special_res;
                rd_addr_o      <= rd_addr_i;
              end else begin
                state <= CALC;
              end
            end else begin
              state <= IDLE;
            end
          end
          CALC: begin
            if (last) begin
              state          <= DONE;
              result_valid_o <= 1'b1;
              result_o       <= fin_res;
              rd_addr_o      <= rd_p0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Testbench for ex_div: directed operations checked against an arithmetic
// reference model and a cycle-stamped expectation queue.
module tb_ex_div;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;
  logic [4:0]      rd_addr_o;
  logic            reg_wen_o;

  ex_div #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int          at;
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: RISC-V divide semantics in plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = signed'(a);
    sb = signed'(b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return unsigned'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return unsigned'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Every cycle: a writeback must appear exactly when the model schedules one.
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() > 0 && q[0].at == cyc) begin
        chk("valid", {31'd0, result_valid_o}, 32'd1);
        chk("wen", {31'd0, reg_wen_o}, 32'd1);
        chk("result", result_o, q[0].res);
        chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, q[0].rd});
        void'(q.pop_front());
      end else begin
        chk("idle_valid", {31'd0, result_valid_o}, 32'd0);
        chk("idle_wen", {31'd0, reg_wen_o}, 32'd0);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  task automatic chk_busy(input logic exp, input string name);
    #1;
    chk(name, {31'd0, busy_o}, {31'd0, exp});
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after accept.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    exp_t e;
    op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd; start_i = 1'b1;
    chk_busy(1'b1, "busy_req");
    @(posedge clk);
    #1;
    e.at  = cyc + (is_special(op, a, b) ? 0 : XLEN);
    e.res = model(op, a, b);
    e.rd  = rd;
    q.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    op_i = 2'($urandom); dividend_i = $urandom; divisor_i = $urandom;
    rd_addr_i = 5'($urandom);
  endtask

  task automatic calc_span();
    for (int k = 0; k < XLEN; k++) begin
      chk_busy(1'b1, "busy_calc");
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    launch(op, a, b, rd);
    if (!is_special(op, a, b)) calc_span();
    chk_busy(1'b0, "busy_done");
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    #1;
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_result"}, result_o, 32'd0);
    chk({tag, "_valid"}, {31'd0, result_valid_o}, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd_addr_o}, 32'd0);
    chk({tag, "_wen"}, {31'd0, reg_wen_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00;
    dividend_i = '0; divisor_i = '0; rd_addr_i = '0;

    // Hand-computed pins on the model itself.
    chk("pin_divu", model(2'b01, 32'd100, 32'd7), 32'd14);
    chk("pin_remu", model(2'b11, 32'd100, 32'd7), 32'd2);
    chk("pin_div_neg", model(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem_neg", model(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_rem_negb", model(2'b10, 32'd7, 32'hFFFF_FFFE), 32'd1);
    chk("pin_div0", model(2'b01, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("pin_ovf", model(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run_op(2'b01, 32'd100, 32'd7, 5'd3);
    run_op(2'b11, 32'd100, 32'd7, 5'd4);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd8);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd9);
    run_op(2'b01, 32'd5, 32'd0, 5'd10);
    run_op(2'b10, 32'd5, 32'd0, 5'd11);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd14);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd15);
    run_op(2'b00, 32'h8000_0000, 32'd2, 5'd16);
    run_op(2'b11, 32'hDEAD_BEEF, 32'h0001_2345, 5'd17);
    run_op(2'b01, 32'd0, 32'd9, 5'd18);

    // Flush mid-calculation: pending result is cancelled.
    launch(2'b01, 32'd100, 32'd7, 5'd19);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    @(negedge clk);
    flush_i = 1'b0;
    chk_busy(1'b0, "busy_after_flush");
    repeat (40) @(negedge clk);

    // Reset mid-calculation: everything returns to zero.
    launch(2'b01, 32'd100, 32'd7, 5'd20);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Back-to-back: new op accepted in the DONE cycle.
    launch(2'b01, 32'd100, 32'd7, 5'd3);
    calc_span();
    launch(2'b01, 32'd9, 32'd3, 5'd5);
    calc_span();
    chk_busy(1'b0, "busy_done_b2b");
    repeat (3) @(negedge clk);

    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL pending: %0d expected writebacks never checked", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
